// File: rtl/alu4_nibble_sequencer_if.sv
// Command/response handshake bundle between the host logic and the nibble sequencer.
// The host drives the command and rsp_ready; the sequencer drives the rest.
interface alu4_nibble_sequencer_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = 4 * NIBBLES;

    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         cmd_math_ci;
    logic         cmd_rot_ci;
    logic         cmd_msb_first;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_math_co;
    logic         rsp_rot_co;
    logic         rsp_ovf;
    logic         rsp_zero;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_math_ci, cmd_rot_ci, cmd_msb_first,
        output rsp_ready,
        input  cmd_ready,
        input  rsp_valid, rsp_result, rsp_math_co, rsp_rot_co, rsp_ovf, rsp_zero
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_math_ci, cmd_rot_ci, cmd_msb_first,
        input  rsp_ready,
        output cmd_ready,
        output rsp_valid, rsp_result, rsp_math_co, rsp_rot_co, rsp_ovf, rsp_zero
    );
endinterface

// File: rtl/alu4_nibble_sequencer.sv
// Runs one wide ALU command through the 4-bit ALU one nibble per cycle, chaining
// math/rotate carries in processing order, and returns the assembled result and flags.
module alu4_nibble_sequencer #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu4_nibble_sequencer_if.slave  bus,
    output logic [3:0]              alu_op,
    output logic [3:0]              alu_a,
    output logic [3:0]              alu_b,
    output logic                    alu_math_ci,
    output logic                    alu_rot_ci,
    input  logic [3:0]              alu_out,
    input  logic                    alu_math_co,
    input  logic                    alu_rot_co,
    input  logic                    alu_ovf,
    input  logic                    alu_zero
);
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [3:0]               op_q;
    logic [NIBBLES-1:0][3:0]  a_q;
    logic [NIBBLES-1:0][3:0]  b_q;
    logic [NIBBLES-1:0][3:0]  res_q;
    logic                     dir_q;
    logic                     mc_q;
    logic                     rc_q;
    logic                     zero_q;
    logic                     ovf_q;
    logic [IW-1:0]            idx_q;
    logic [IW-1:0]            cnt_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the combinational drive of the ALU while running
    always_comb begin
        state_d     = state_q;
        alu_op      = 4'd0;
        alu_a       = 4'd0;
        alu_b       = 4'd0;
        alu_math_ci = 1'b0;
        alu_rot_ci  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) state_d = RUN;
            end
            RUN: begin
                alu_op      = op_q;
                alu_a       = a_q[idx_q];
                alu_b       = b_q[idx_q];
                alu_math_ci = mc_q;
                alu_rot_ci  = rc_q;
                if (cnt_q == IW'(NIBBLES - 1)) state_d = DONE;
            end
            DONE: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Command capture and per-nibble accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            dir_q  <= 1'b0;
            mc_q   <= 1'b0;
            rc_q   <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            idx_q  <= '0;
            cnt_q  <= '0;
        end else if (state_q == IDLE && bus.cmd_valid) begin
            op_q   <= bus.cmd_op;
            a_q    <= bus.cmd_a;
            b_q    <= bus.cmd_b;
            res_q  <= '0;
            dir_q  <= bus.cmd_msb_first;
            mc_q   <= bus.cmd_math_ci;
            rc_q   <= bus.cmd_rot_ci;
            zero_q <= 1'b1;
            idx_q  <= bus.cmd_msb_first ? IW'(NIBBLES - 1) : '0;
            cnt_q  <= '0;
        end else if (state_q == RUN) begin
            res_q[idx_q] <= alu_out;
            mc_q         <= alu_math_co;
            rc_q         <= alu_rot_co;
            zero_q       <= zero_q & alu_zero;
            ovf_q        <= alu_ovf;
            idx_q        <= dir_q ? idx_q - IW'(1) : idx_q + IW'(1);
            cnt_q        <= cnt_q + IW'(1);
        end
    end

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.rsp_valid   = (state_q == DONE);
    assign bus.rsp_result  = res_q;
    assign bus.rsp_math_co = mc_q;
    assign bus.rsp_rot_co  = rc_q;
    assign bus.rsp_ovf     = ovf_q;
    assign bus.rsp_zero    = zero_q;
endmodule

// File: tb/tb_alu4_nibble_sequencer.sv
// Randomized and directed bench for alu4_nibble_sequencer against a wide-operand
// reference model, with an add-only 4-bit ALU model closing the loop.
module tb_alu4_nibble_sequencer;
    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;

    logic       clk;
    logic       rst_n;
    logic [3:0] alu_op, alu_a, alu_b, alu_out;
    logic       alu_math_ci, alu_rot_ci, alu_math_co, alu_rot_co, alu_ovf, alu_zero;
    logic [4:0] alu_sum;

    int total = 0;
    int bad   = 0;

    alu4_nibble_sequencer_if #(.NIBBLES(NIBBLES)) bus ();

    alu4_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_math_ci (alu_math_ci),
        .alu_rot_ci  (alu_rot_ci),
        .alu_out     (alu_out),
        .alu_math_co (alu_math_co),
        .alu_rot_co  (alu_rot_co),
        .alu_ovf     (alu_ovf),
        .alu_zero    (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Add-only 4-bit ALU model
    always_comb begin
        alu_sum     = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_math_ci};
        alu_out     = alu_sum[3:0];
        alu_math_co = alu_sum[4];
        alu_rot_co  = alu_a[3];
        alu_zero    = (alu_sum[3:0] == 4'd0);
        alu_ovf     = (alu_a[3] == alu_b[3]) && (alu_sum[3] != alu_a[3]);
    end

    logic [W-1:0] exp_res;
    logic         exp_mco, exp_rco, exp_ovf, exp_zero;
    logic [3:0]   exp_na[NIBBLES];
    logic         exp_rci[NIBBLES];
    logic [3:0]   cur_op;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic mci, input logic rci, input logic msb);
        logic [W:0] s;
        logic [4:0] s5;
        logic       mc;
        int         k;
        for (int j = 0; j < int'(NIBBLES); j++) begin
            k         = msb ? int'(NIBBLES) - 1 - j : j;
            exp_na[j] = a[4*k +: 4];
            if (j == 0) exp_rci[j] = rci;
            else        exp_rci[j] = exp_na[j-1][3];
        end
        if (!msb) begin
            s        = {1'b0, a} + {1'b0, b} + (W+1)'(mci);
            exp_res  = s[W-1:0];
            exp_mco  = s[W];
            exp_ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            exp_zero = (s[W-1:0] == '0);
            exp_rco  = a[W-1];
        end else begin
            mc       = mci;
            exp_zero = 1'b1;
            exp_ovf  = 1'b0;
            for (int n = int'(NIBBLES) - 1; n >= 0; n--) begin
                s5               = {1'b0, a[4*n +: 4]} + {1'b0, b[4*n +: 4]} + 5'(mc);
                exp_res[4*n +: 4] = s5[3:0];
                mc               = s5[4];
                exp_ovf          = (a[4*n+3] == b[4*n+3]) && (s5[3] != a[4*n+3]);
                exp_zero         = exp_zero & (s5[3:0] == 4'd0);
            end
            exp_mco = mc;
            exp_rco = a[3];
        end
    endtask

    // Present a command and return just after the accepting edge
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic mci, input logic rci, input logic msb);
        int n;
        bus.cmd_op        = op;
        bus.cmd_a         = a;
        bus.cmd_b         = b;
        bus.cmd_math_ci   = mci;
        bus.cmd_rot_ci    = rci;
        bus.cmd_msb_first = msb;
        bus.cmd_valid     = 1'b1;
        cur_op            = op;
        ref_model(a, b, mci, rci, msb);
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_ready_wait", 64'(bus.cmd_ready), 64'(1));
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Follow a running command to DONE and compare the response with the model
    task automatic collect();
        int lat;
        lat = 0;
        while (!bus.rsp_valid && lat < 4 * int'(NIBBLES)) begin
            if (lat < int'(NIBBLES)) begin
                check("alu_a",      64'(alu_a),      64'(exp_na[lat]));
                check("alu_rot_ci", 64'(alu_rot_ci), 64'(exp_rci[lat]));
                check("alu_op",     64'(alu_op),     64'(cur_op));
                check("cmd_ready_run", 64'(bus.cmd_ready), 64'(0));
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency",     64'(lat),             64'(NIBBLES));
        check("rsp_result",  64'(bus.rsp_result),  64'(exp_res));
        check("rsp_math_co", 64'(bus.rsp_math_co), 64'(exp_mco));
        check("rsp_rot_co",  64'(bus.rsp_rot_co),  64'(exp_rco));
        check("rsp_ovf",     64'(bus.rsp_ovf),     64'(exp_ovf));
        check("rsp_zero",    64'(bus.rsp_zero),    64'(exp_zero));
        check("alu_a_done",  64'({alu_op, alu_a, alu_b}), 64'(0));
    endtask

    task automatic finish_rsp(input int stall);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        check("rsp_hold", 64'(bus.rsp_result), 64'(exp_res));
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("rsp_valid_after", 64'(bus.rsp_valid), 64'(0));
        check("cmd_ready_after", 64'(bus.cmd_ready), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] hold_res;
        logic         seen;

        rst_n             = 1'b0;
        bus.cmd_valid     = 1'b0;
        bus.cmd_op        = 4'd0;
        bus.cmd_a         = '0;
        bus.cmd_b         = '0;
        bus.cmd_math_ci   = 1'b0;
        bus.cmd_rot_ci    = 1'b0;
        bus.cmd_msb_first = 1'b0;
        bus.rsp_ready     = 1'b0;
        cur_op            = 4'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready",  64'(bus.cmd_ready),  64'(1));
        check("rst_rsp_valid",  64'(bus.rsp_valid),  64'(0));
        check("rst_rsp_result", 64'(bus.rsp_result), 64'(0));
        check("rst_rsp_flags",  64'({bus.rsp_math_co, bus.rsp_rot_co, bus.rsp_ovf, bus.rsp_zero}), 64'(0));
        check("rst_alu",        64'({alu_op, alu_a, alu_b, alu_math_ci, alu_rot_ci}), 64'(0));

        issue(4'h3, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0); collect(); finish_rsp(0);
        issue(4'h3, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0); collect(); finish_rsp(0);
        issue(4'h3, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0); collect(); finish_rsp(0);
        issue(4'h5, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b1); collect(); finish_rsp(0);

        // Back-pressure with a waiting command, then accept right after DONE clears
        issue(4'h3, 16'hA5C3, 16'h1F0E, 1'b1, 1'b0, 1'b0);
        collect();
        hold_res          = exp_res;
        bus.cmd_op        = 4'h3;
        bus.cmd_a         = 16'h8001;
        bus.cmd_b         = 16'h8001;
        bus.cmd_math_ci   = 1'b0;
        bus.cmd_rot_ci    = 1'b0;
        bus.cmd_msb_first = 1'b1;
        bus.cmd_valid     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_rsp_result", 64'(bus.rsp_result), 64'(hold_res));
            check("bp_rsp_valid",  64'(bus.rsp_valid),  64'(1));
            check("bp_cmd_ready",  64'(bus.cmd_ready),  64'(0));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("bp_idle_ready", 64'(bus.cmd_ready), 64'(1));
        check("bp_idle_valid", 64'(bus.rsp_valid), 64'(0));
        cur_op = 4'h3;
        ref_model(16'h8001, 16'h8001, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check("bp_accepted", 64'(bus.cmd_ready), 64'(0));
        collect();
        finish_rsp(2);

        // Reset after the second RUN edge aborts the command
        issue(4'h3, 16'h4321, 16'h1111, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_cmd_ready",  64'(bus.cmd_ready),  64'(1));
        check("abort_rsp_result", 64'(bus.rsp_result), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (NIBBLES + 3) begin
            @(posedge clk); #1;
            seen = seen | bus.rsp_valid;
        end
        check("abort_no_rsp",    64'(seen),           64'(0));
        check("abort_idle",      64'(bus.cmd_ready),  64'(1));
        check("abort_result",    64'(bus.rsp_result), 64'(0));
        check("abort_zero_flag", 64'(bus.rsp_zero),   64'(0));
        issue(4'h3, 16'h0F0F, 16'h00F1, 1'b0, 1'b1, 1'b0); collect(); finish_rsp(1);

        for (int t = 0; t < 24; t++) begin
            issue(4'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            collect();
            finish_rsp(int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu4_nibble_sequencer.md
# alu4_nibble_sequencer

Multi-nibble operation sequencer for the 4-bit ALU. It accepts one wide command (NIBBLES×4 bits per operand) over a valid/ready handshake. It then drives the ALU one nibble per cycle, chaining the math and rotate carries between nibbles and writing each ALU result nibble into a result register. Finally it returns the wide result and the aggregated flags over a second valid/ready handshake. It sits between the host/command logic and the combinational ALU instance, which is its only client.

## Interface
- NIBBLES, 4, operand width in nibbles (W = 4×NIBBLES); legal range 2..8.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer accepts a command this cycle.
- cmd_op  in  4  ALU opcode, applied unchanged to every nibble.
- cmd_a / cmd_b  in  W  operands.
- cmd_math_ci / cmd_rot_ci  in  1  carry-ins for the first processed nibble.
- cmd_msb_first  in  1  1: process nibble NIBBLES-1 down to 0 (right shifts/rotates); 0: nibble 0 upward.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_result  out  W  assembled result.
- rsp_math_co / rsp_rot_co  out  1  carry-outs of the last processed nibble.
- rsp_ovf  out  1  overflow flag of the last processed nibble.
- rsp_zero  out  1  1 iff every nibble's zero flag was 1.
- alu_op  out  4  opcode to the ALU.
- alu_a / alu_b  out  4  operand nibbles to the ALU.
- alu_math_ci / alu_rot_ci  out  1  carry-ins to the ALU.
- alu_out  in  4  ALU result nibble (combinational from alu_* outputs).
- alu_math_co / alu_rot_co / alu_ovf / alu_zero  in  1  ALU flags.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, capture cmd_op, cmd_a, cmd_b, cmd_msb_first. Set math/rot carry registers to cmd_math_ci/cmd_rot_ci. Set idx = cmd_msb_first ? NIBBLES-1 : 0. Set cnt=0, zero_acc=1, and clear the result register. Go to RUN.
- RUN: cmd_ready=0. Drive the ALU combinationally with alu_op=op_q, alu_a=a_q[idx], alu_b=b_q[idx], alu_math_ci=mc_q, alu_rot_ci=rc_q. Each edge does all of the following:
  - result[idx] <= alu_out.
  - mc_q <= alu_math_co; rc_q <= alu_rot_co.
  - zero_acc <= zero_acc & alu_zero; ovf_q <= alu_ovf.
  - idx steps by ∓1 per the captured direction; cnt++.
- When cnt==NIBBLES-1 at the edge, transition to DONE.
- The carry chain follows processing order in both directions. With msb_first=1, the rotate carry out of nibble k feeds nibble k-1.
- DONE: rsp_valid=1. rsp_* are the registered values, stable until the handshake. On rsp_ready, go to IDLE.
- cmd_ready and rsp_valid are never high together.
- Outside RUN, all alu_* outputs are 0.
- A command arriving during RUN/DONE is not accepted; cmd_valid must be held by the producer.

## Timing
- Reset (async assert, synchronous-to-clk deassert by the system): state=IDLE, cmd_ready=1, rsp_valid=0, rsp_result=0, all rsp flags 0, alu_* = 0, all internal registers 0 (zero_acc=0).
- Reset asserted mid-RUN or mid-DONE aborts the operation. Nothing is emitted and the partial result is discarded.
- Latency: command accepted at edge E0 → nibbles processed at edges E1..E_NIBBLES → rsp_valid high in the cycle after edge E_NIBBLES.
- Throughput: with rsp_ready held 1, one command every NIBBLES+2 cycles.
- Back-pressure: rsp_valid stays high and rsp_* stay frozen for any number of cycles with rsp_ready=0.
- No combinational path from cmd_valid or rsp_ready to any output except through the state register. The only combinational path is alu_* → (ALU) → alu_out → result register, a single cycle.

## Test plan
The bench ALU model computes {co,out} = a+b+math_ci, rot_co=a[3], zero=(out==0), ovf = signed overflow.
- Reset, then idle 3 cycles → cmd_ready=1, rsp_valid=0, rsp_result=0x0000, alu_a=alu_b=0.
- NIBBLES=4: a=0x00FF, b=0x0001, ci=0, msb_first=0 → rsp_valid exactly 4 cycles after accept; result=0x0100, math_co=0, zero=0, ovf=0.
- a=0xFFFF, b=0x0001 → result=0x0000, math_co=1, zero=1. Then a=0x7FFF, b=0x0001 → result=0x8000, ovf=1, zero=0.
- msb_first=1, a=0x1234, b=0 → alu_a sequence 1,2,3,4 on consecutive RUN cycles; result=0x1234, rot_co = bit 3 of nibble 0 (=0).
- Hold rsp_ready=0 for 10 cycles with cmd_valid=1 throughout → rsp_* stable, cmd_ready=0. Release → next command accepted in the cycle after returning to IDLE.
- Assert rst_n low for 1 cycle after the 2nd RUN edge → rsp_valid never rises, state IDLE, rsp_result=0; the following command completes correctly.
